// File: rtl/iter_divider.sv
// -----------------------------------------------------------------------------
// iter_divider
//   Multicycle radix-2 restoring divider with a start/done handshake. One
//   quotient bit is produced per clock, MSB first, on operand magnitudes; a
//   final FIX cycle applies the signs for two's-complement division.
//   A zero divisor completes immediately with an all-ones quotient.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   start      operation request, accepted only while idle
//   is_signed  1 = signed division, 0 = unsigned (captured with start)
//   SrcA       dividend (captured with start)
//   SrcB       divisor  (captured with start)
//   busy       high while an accepted operation is in flight
//   done       one-cycle completion pulse
//   Quotient   quotient, held until the next completion
//   Remainder  remainder, held until the next completion
//   DivByZero  set with done when the divisor was zero
// -----------------------------------------------------------------------------
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Two's-complement negation, modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + ONE_W;
    endfunction

    // Magnitude of a value whose sign flag is already known.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
        return neg ? negate(v) : v;
    endfunction

    state_t           state_q;
    logic [WIDTH-1:0] rem_q;        // partial remainder; always < divisor, so WIDTH bits suffice
    logic [WIDTH-1:0] quo_q;        // dividend shifts out MSB-first as quotient bits shift in
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quot_out_q;
    logic [WIDTH-1:0] rem_out_q;

    logic [WIDTH:0]   rem_shift_s;  // WIDTH+1-bit shifted partial remainder
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    // One restoring iteration: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift_s = {rem_q, quo_q[WIDTH-1]};
        rem_d       = rem_q;
        quo_d       = quo_q;
        if (rem_shift_s >= {1'b0, dvs_q}) begin
            rem_d = rem_shift_s[WIDTH-1:0] - dvs_q;
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = rem_shift_s[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            rem_q      <= ZERO_W;
            quo_q      <= ZERO_W;
            dvs_q      <= ZERO_W;
            cnt_q      <= {CW{1'b0}};
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            quot_out_q <= ZERO_W;
            rem_out_q  <= ZERO_W;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (SrcB == ZERO_W) begin
                            // Zero divisor: complete at once, never enter RUN.
                            quot_out_q <= ONES_W;
                            rem_out_q  <= SrcA;
                            dbz_q      <= 1'b1;
                            done_q     <= 1'b1;
                            state_q    <= S_IDLE;
                        end else begin
                            sign_a_q <= is_signed & SrcA[WIDTH-1];
                            sign_b_q <= is_signed & SrcB[WIDTH-1];
                            quo_q    <= magnitude(SrcA, is_signed & SrcA[WIDTH-1]);
                            dvs_q    <= magnitude(SrcB, is_signed & SrcB[WIDTH-1]);
                            rem_q    <= ZERO_W;
                            cnt_q    <= {CW{1'b0}};
                            busy_q   <= 1'b1;
                            dbz_q    <= 1'b0;
                            state_q  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Quotient truncates toward zero; remainder follows the dividend.
                    // MIN / -1 wraps back to MIN through the modular negation.
                    quot_out_q <= (sign_a_q ^ sign_b_q) ? negate(quo_q) : quo_q;
                    rem_out_q  <= sign_a_q ? negate(rem_q) : rem_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign Quotient  = quot_out_q;
    assign Remainder = rem_out_q;
    assign DivByZero = dbz_q;

endmodule
